// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: 16 x 8-bit register file shared by an I2C target core (toggle handshakes) and a host port.
// Core events are resynchronised into clk and act on the 3rd clk edge after the toggle; host port is same-cycle.
// Optional pointer auto-increment after each data write/read: define I2C_REG_BANK_AUTOINC_EN.
module i2c_reg_bank (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_tgl,
  input  logic       stop_tgl,
  input  logic       rw_n,
  input  logic       wbyte_tgl,
  input  logic [7:0] wbyte,
  input  logic       rreq_tgl,
  output logic [7:0] rd_data,
  output logic       rd_ack_tgl,
  input  logic       host_we,
  input  logic [3:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       i2c_wr_stb,
  output logic [3:0] i2c_wr_addr
);

  typedef enum logic [1:0] {ST_IDLE, ST_PTR, ST_WDATA, ST_RDATA} state_e;

  // Bit positions of the four core events inside the synchroniser vectors.
  localparam int EV_START = 0;
  localparam int EV_STOP  = 1;
  localparam int EV_WBYTE = 2;
  localparam int EV_RREQ  = 3;

`ifdef I2C_REG_BANK_AUTOINC_EN
  localparam logic [3:0] PTR_STEP = 4'd1;
`else
  localparam logic [3:0] PTR_STEP = 4'd0;
`endif

  logic [3:0] tgl_in;
  logic [3:0] sync1_q, sync2_q, edge_q;
  logic [3:0] ev;
  logic [1:0] arm_q;

  state_e     state_q, state_d;
  logic [3:0] ptr_q, ptr_d;
  logic [7:0] regs_q [16];
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_ack_q, rd_ack_d;
  logic       wr_stb_q, wr_stb_d;
  logic [3:0] wr_addr_q, wr_addr_d;
  logic       i2c_we;

  assign tgl_in = {rreq_tgl, wbyte_tgl, stop_tgl, start_tgl};

  // Two-flop synchroniser followed by the edge-detect reference flop for each toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
      edge_q  <= 4'b0000;
    end else begin
      sync1_q <= tgl_in;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  // After reset the edge flop must first catch up with the live toggle levels, so events stay masked until the pipe is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q <= 2'd0;
    end else if (arm_q != 2'd3) begin
      arm_q <= arm_q + 2'd1;
    end
  end

  assign ev = (arm_q == 2'd3) ? (sync2_q ^ edge_q) : 4'b0000;

  // Transaction FSM: stop beats start beats byte/read-request; dropped events leave no trace.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rd_data_d = rd_data_q;
    rd_ack_d  = rd_ack_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    i2c_we    = 1'b0;
    if (ev[EV_STOP]) begin
      state_d = ST_IDLE;
    end else if (ev[EV_START]) begin
      state_d = rw_n ? ST_RDATA : ST_PTR;
    end else begin
      if (ev[EV_WBYTE]) begin
        case (state_q)
          ST_PTR: begin
            ptr_d   = wbyte[3:0];
            state_d = ST_WDATA;
          end
          ST_WDATA: begin
            i2c_we    = 1'b1;
            wr_stb_d  = 1'b1;
            wr_addr_d = ptr_q;
            ptr_d     = ptr_q + PTR_STEP;
          end
          default: ;
        endcase
      end
      if (ev[EV_RREQ]) begin
        rd_ack_d = ~rd_ack_q;
        if (state_q == ST_RDATA) begin
          rd_data_d = regs_q[ptr_q];
          ptr_d     = ptr_q + PTR_STEP;
        end else begin
          rd_data_d = 8'hFF;
        end
      end
    end
  end

  // FSM, pointer and core-facing output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 4'h0;
      rd_data_q <= 8'h00;
      rd_ack_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= 4'h0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rd_data_q <= rd_data_d;
      rd_ack_q  <= rd_ack_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  // Register file: host write is issued last so it wins a same-index collision with an I2C write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      if (i2c_we) begin
        regs_q[ptr_q] <= wbyte;
      end
      if (host_we) begin
        regs_q[host_addr] <= host_wdata;
      end
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_ack_tgl  = rd_ack_q;
  assign i2c_wr_stb  = wr_stb_q;
  assign i2c_wr_addr = wr_addr_q;
  assign host_rdata  = regs_q[host_addr];

endmodule

// File: tb/tb_i2c_reg_bank.sv
// tb_i2c_reg_bank: directed vector table, hand-timed corner sequences and a randomized run against a reference model.
module tb_i2c_reg_bank;

`ifdef I2C_REG_BANK_AUTOINC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif

  localparam int OP_STW  = 0;
  localparam int OP_STR  = 1;
  localparam int OP_STOP = 2;
  localparam int OP_WB   = 3;
  localparam int OP_RR   = 4;
  localparam int OP_HW   = 5;

  logic       clk, rst_n;
  logic       start_tgl, stop_tgl, rw_n, wbyte_tgl, rreq_tgl, host_we;
  logic [7:0] wbyte, host_wdata, rd_data, host_rdata;
  logic [3:0] host_addr, i2c_wr_addr;
  logic       rd_ack_tgl, i2c_wr_stb;

  int nvec = 0;
  int nmis = 0;
  int stb_cnt = 0;

  typedef struct {
    int         op;
    logic [3:0] a;
    logic [7:0] d;
    logic [3:0] ci;
    logic [7:0] er;
    logic [7:0] erd;
    logic       eack;
  } vec_t;
  vec_t tbl [18];

  // Reference model state: mode 0=idle 1=expect pointer 2=write data 3=read data.
  logic [7:0] m_regs [16];
  logic [3:0] m_ptr;
  int         m_mode;
  logic [7:0] m_rd;
  logic       m_ack;
  int         m_stb;

  i2c_reg_bank dut (
    .clk(clk), .rst_n(rst_n),
    .start_tgl(start_tgl), .stop_tgl(stop_tgl), .rw_n(rw_n),
    .wbyte_tgl(wbyte_tgl), .wbyte(wbyte), .rreq_tgl(rreq_tgl),
    .rd_data(rd_data), .rd_ack_tgl(rd_ack_tgl),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .i2c_wr_stb(i2c_wr_stb), .i2c_wr_addr(i2c_wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count write strobes sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && i2c_wr_stb) stb_cnt <= stb_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic rd_reg(input logic [3:0] i, output logic [7:0] v);
    host_addr = i;
    #1;
    v = host_rdata;
  endtask

  // Apply one transaction at a falling edge, then let it pass the 3-edge synchroniser with margin.
  task automatic do_op(input int op, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    case (op)
      OP_STW:  begin rw_n = 1'b0; start_tgl = ~start_tgl; end
      OP_STR:  begin rw_n = 1'b1; start_tgl = ~start_tgl; end
      OP_STOP: stop_tgl = ~stop_tgl;
      OP_WB:   begin wbyte = d; wbyte_tgl = ~wbyte_tgl; end
      OP_RR:   rreq_tgl = ~rreq_tgl;
      default: begin
        host_we = 1'b1; host_addr = a; host_wdata = d;
        @(negedge clk);
        host_we = 1'b0;
      end
    endcase
    repeat (4) @(posedge clk);
    #1;
  endtask

  // I2C data write and host write land on the same clk edge.
  task automatic collide(input logic [7:0] pb, input logic [7:0] iv, input logic [3:0] ha, input logic [7:0] hv);
    do_op(OP_STW, 4'h0, 8'h00);
    do_op(OP_WB, 4'h0, pb);
    @(negedge clk);
    wbyte = iv; wbyte_tgl = ~wbyte_tgl;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    host_we = 1'b1; host_addr = ha; host_wdata = hv;
    @(posedge clk);
    #1;
    host_we = 1'b0;
    chk("coll_stb", 32'(i2c_wr_stb), 32'd1);
    chk("coll_stb_addr", 32'(i2c_wr_addr), 32'(pb[3:0]));
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] v;
    int base;

    rst_n = 1'b0; start_tgl = 1'b0; stop_tgl = 1'b0; rw_n = 1'b0;
    wbyte_tgl = 1'b0; wbyte = 8'h00; rreq_tgl = 1'b0;
    host_we = 1'b0; host_addr = 4'h0; host_wdata = 8'h00;

    tbl[0]  = '{OP_STW,  4'h0, 8'h00, 4'h0, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{OP_WB,   4'h0, 8'h03, 4'h3, 8'h00, 8'h00, 1'b0};
    tbl[2]  = '{OP_WB,   4'h0, 8'hA5, 4'h3, 8'hA5, 8'h00, 1'b0};
    tbl[3]  = '{OP_WB,   4'h0, 8'h5A, (AI ? 4'h4 : 4'h3), 8'h5A, 8'h00, 1'b0};
    tbl[4]  = '{OP_STOP, 4'h0, 8'h00, 4'h3, (AI ? 8'hA5 : 8'h5A), 8'h00, 1'b0};
    tbl[5]  = '{OP_RR,   4'h0, 8'h00, 4'h3, (AI ? 8'hA5 : 8'h5A), 8'hFF, 1'b1};
    tbl[6]  = '{OP_HW,   4'hF, 8'h11, 4'hF, 8'h11, 8'hFF, 1'b1};
    tbl[7]  = '{OP_HW,   4'h0, 8'h22, 4'h0, 8'h22, 8'hFF, 1'b1};
    tbl[8]  = '{OP_STW,  4'h0, 8'h00, 4'hF, 8'h11, 8'hFF, 1'b1};
    tbl[9]  = '{OP_WB,   4'h0, 8'h0F, 4'hF, 8'h11, 8'hFF, 1'b1};
    tbl[10] = '{OP_STR,  4'h0, 8'h00, 4'h0, 8'h22, 8'hFF, 1'b1};
    tbl[11] = '{OP_RR,   4'h0, 8'h00, 4'hF, 8'h11, 8'h11, 1'b0};
    tbl[12] = '{OP_RR,   4'h0, 8'h00, 4'h0, 8'h22, (AI ? 8'h22 : 8'h11), 1'b1};
    tbl[13] = '{OP_STOP, 4'h0, 8'h00, 4'h4, (AI ? 8'h5A : 8'h00), (AI ? 8'h22 : 8'h11), 1'b1};
    tbl[14] = '{OP_RR,   4'h0, 8'h00, 4'hF, 8'h11, 8'hFF, 1'b0};
    tbl[15] = '{OP_STR,  4'h0, 8'h00, 4'h0, 8'h22, 8'hFF, 1'b0};
    tbl[16] = '{OP_RR,   4'h0, 8'h00, 4'h1, 8'h00, (AI ? 8'h00 : 8'h11), 1'b1};
    tbl[17] = '{OP_STOP, 4'h0, 8'h00, 4'h0, 8'h22, (AI ? 8'h00 : 8'h11), 1'b1};

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd_data", 32'(rd_data), 32'h00);
    chk("rst_rd_ack", 32'(rd_ack_tgl), 32'd0);
    chk("rst_wr_stb", 32'(i2c_wr_stb), 32'd0);
    chk("rst_wr_addr", 32'(i2c_wr_addr), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Directed vector table.
    base = stb_cnt;
    for (int i = 0; i < 18; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].d);
      rd_reg(tbl[i].ci, v);
      chk($sformatf("tbl%0d_reg%0h", i, tbl[i].ci), 32'(v), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_rd_data", i), 32'(rd_data), 32'(tbl[i].erd));
      chk($sformatf("tbl%0d_rd_ack", i), 32'(rd_ack_tgl), 32'(tbl[i].eack));
    end
    chk("tbl_stb_count", 32'(stb_cnt - base), 32'd2);

    // Write lands exactly on the 3rd edge after the toggle.
    do_op(OP_HW, 4'h8, 8'h00);
    do_op(OP_STW, 4'h0, 8'h00);
    do_op(OP_WB, 4'h0, 8'h08);
    @(negedge clk);
    wbyte = 8'hC3; wbyte_tgl = ~wbyte_tgl;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      rd_reg(4'h8, v);
      chk($sformatf("timing_edge%0d", e), 32'(v), (e == 3) ? 32'hC3 : 32'h00);
    end
    chk("timing_stb", 32'(i2c_wr_stb), 32'd1);
    chk("timing_stb_addr", 32'(i2c_wr_addr), 32'h8);

    // Host/I2C write collisions: same index then different index.
    collide(8'h05, 8'h33, 4'h5, 8'h77);
    rd_reg(4'h5, v);
    chk("coll_same_idx", 32'(v), 32'h77);
    collide(8'h05, 8'h44, 4'h9, 8'h99);
    rd_reg(4'h5, v);
    chk("coll_diff_i2c", 32'(v), 32'h44);
    rd_reg(4'h9, v);
    chk("coll_diff_host", 32'(v), 32'h99);

    // Mid-transaction reset; toggle inputs are left at non-zero levels.
    do_op(OP_STW, 4'h0, 8'h00);
    do_op(OP_WB, 4'h0, 8'h07);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_data", 32'(rd_data), 32'h00);
    chk("mid_rst_rd_ack", 32'(rd_ack_tgl), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      rd_reg(4'(i), v);
      chk($sformatf("post_rst_reg%0h", i), 32'(v), 32'h00);
    end
    chk("post_rst_rd_ack", 32'(rd_ack_tgl), 32'd0);
    chk("post_rst_rd_data", 32'(rd_data), 32'h00);
    base = stb_cnt;
    do_op(OP_WB, 4'h0, 8'hEE);
    chk("post_rst_wb_stb", 32'(stb_cnt - base), 32'd0);
    rd_reg(4'h7, v);
    chk("post_rst_wb_reg7", 32'(v), 32'h00);
    rd_reg(4'h0, v);
    chk("post_rst_wb_reg0", 32'(v), 32'h00);
    do_op(OP_HW, 4'h0, 8'hAB);
    do_op(OP_HW, 4'h7, 8'hCD);
    do_op(OP_STR, 4'h0, 8'h00);
    do_op(OP_RR, 4'h0, 8'h00);
    chk("post_rst_ptr0_read", 32'(rd_data), 32'hAB);
    chk("post_rst_ptr0_ack", 32'(rd_ack_tgl), 32'd1);

    // Randomized run against the reference model, seeded with the state reached above.
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_regs[0] = 8'hAB;
    m_regs[7] = 8'hCD;
    m_ptr  = AI ? 4'h1 : 4'h0;
    m_mode = 3;
    m_rd   = 8'hAB;
    m_ack  = 1'b1;
    m_stb  = 0;
    base   = stb_cnt;
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [7:0] d;
      logic [3:0] a;
      logic [3:0] ri;
      r  = $urandom_range(0, 9);
      d  = 8'($urandom);
      a  = 4'($urandom);
      ri = 4'($urandom);
      case (r)
        0: begin do_op(OP_STW, 4'h0, 8'h00); m_mode = 1; end
        1: begin do_op(OP_STR, 4'h0, 8'h00); m_mode = 3; end
        2: begin do_op(OP_STOP, 4'h0, 8'h00); m_mode = 0; end
        3, 4, 5: begin
          do_op(OP_WB, 4'h0, d);
          if (m_mode == 1) begin
            m_ptr = d[3:0];
            m_mode = 2;
          end else if (m_mode == 2) begin
            m_regs[m_ptr] = d;
            m_stb++;
            if (AI) m_ptr = m_ptr + 4'd1;
          end
        end
        6, 7: begin
          do_op(OP_RR, 4'h0, 8'h00);
          m_ack = ~m_ack;
          if (m_mode == 3) begin
            m_rd = m_regs[m_ptr];
            if (AI) m_ptr = m_ptr + 4'd1;
          end else begin
            m_rd = 8'hFF;
          end
        end
        default: begin
          do_op(OP_HW, a, d);
          m_regs[a] = d;
        end
      endcase
      chk($sformatf("rnd%0d_rd_data", n), 32'(rd_data), 32'(m_rd));
      chk($sformatf("rnd%0d_rd_ack", n), 32'(rd_ack_tgl), 32'(m_ack));
      chk($sformatf("rnd%0d_stb_count", n), 32'(stb_cnt - base), 32'(m_stb));
      rd_reg(ri, v);
      chk($sformatf("rnd%0d_reg%0h", n, ri), 32'(v), 32'(m_regs[ri]));
    end
    for (int i = 0; i < 16; i++) begin
      rd_reg(4'(i), v);
      chk($sformatf("final_reg%0h", i), 32'(v), 32'(m_regs[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/i2c_reg_bank.md
I2C_REG_BANK -- requirements
Module: i2c_reg_bank

Interface
REQ-001 clk  input  1  system clock; all block state on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 start_tgl  input  1  toggles once per START from SCL-domain core; asynchronous to clk.
REQ-004 stop_tgl  input  1  toggles once per STOP; asynchronous to clk.
REQ-005 rw_n  input  1  R/W bit of matched address; stable before start_tgl toggles; 0=write, 1=read.
REQ-006 wbyte_tgl  input  1  toggles once per received write byte.
REQ-007 wbyte  input  8  received byte; stable from wbyte_tgl toggle until next toggle.
REQ-008 rreq_tgl  input  1  toggles once per read byte requested by core.
REQ-009 rd_data  output  8  byte for core to shift out; held stable between rd_ack_tgl toggles.
REQ-010 rd_ack_tgl  output  1  toggles when rd_data updated for current rreq.
REQ-011 host_we  input  1  host write strobe (clk domain).
REQ-012 host_addr  input  4  host register index.
REQ-013 host_wdata  input  8  host write data.
REQ-014 host_rdata  output  8  combinational regs[host_addr].
REQ-015 i2c_wr_stb  output  1  one-clk pulse when I2C writes a register.
REQ-016 i2c_wr_addr  output  4  index written; valid with i2c_wr_stb.

Function
REQ-017 Storage: 16 x 8-bit registers, index 0x0-0xF; 4-bit pointer ptr.
REQ-018 Each *_tgl input passes 2-flop synchronizer plus edge-detect flop; event acts on 3rd clk edge after toggle; wbyte captured on that same edge.
REQ-019 FSM states IDLE, PTR, WDATA, RDATA.
REQ-020 start event: rw_n=0 -> PTR; rw_n=1 -> RDATA; from any state (repeated START).
REQ-021 PTR + wbyte event: ptr <= wbyte[3:0]; wbyte[7:4] ignored; -> WDATA.
REQ-022 WDATA + wbyte event: regs[ptr] <= wbyte; i2c_wr_stb=1 and i2c_wr_addr=ptr next cycle; ptr update per REQ-032.
REQ-023 RDATA + rreq event: rd_data <= regs[ptr]; rd_ack_tgl toggles same edge; ptr update per REQ-032.
REQ-024 stop event: -> IDLE; ptr retained.
REQ-025 wbyte event in IDLE or RDATA, or rreq event in IDLE/PTR/WDATA: ignored; no state, ptr or regs change; rreq in those states still toggles rd_ack_tgl with rd_data=0xFF.
REQ-026 Same-cycle events priority: stop > start > byte/rreq; lower-priority event dropped.
REQ-027 Host write and I2C write same cycle, same index: host value stored; i2c_wr_stb still pulses.
REQ-028 Host write, different index, same cycle: both stored.
REQ-029 Pointer arithmetic 4-bit modulo 16; 0xF+1 -> 0x0.
REQ-030 host_rdata reflects write on following cycle (no bypass).

Reset
REQ-031 rst_n low: FSM=IDLE, ptr=0, regs all 0x00, rd_data=0x00, rd_ack_tgl=0, i2c_wr_stb=0, i2c_wr_addr=0, sync/edge flops=0; edge-detect flops reload from synchronizers one cycle after release so pre-reset toggle level not seen as event; mid-transaction reset drops transaction.

Configuration
REQ-032 Macro I2C_REG_BANK_AUTOINC_EN: defined -> ptr increments by 1 after each WDATA write and each RDATA read; undefined -> ptr changes only in PTR state.

Verification
REQ-033 start(rw_n=0), bytes 0x03,0xA5,0x5A, stop -> regs[3]=0xA5, regs[4]=0x5A (AUTOINC) or regs[3]=0x5A (no AUTOINC); two i2c_wr_stb pulses.
REQ-034 regs[0xF]=0x11, regs[0]=0x22; write ptr 0x0F, repeated start rw_n=1, two rreq -> rd_data 0x11 then 0x22, rd_ack_tgl toggles twice.
REQ-035 Host write idx 5 = 0x77 same cycle as I2C write idx 5 = 0x33 -> regs[5]=0x77, i2c_wr_stb with addr 5.
REQ-036 wbyte_tgl toggle -> regs updated exactly 3 clk edges later; no earlier change.
REQ-037 rst_n asserted after pointer byte 0x07 -> all regs 0, ptr 0; next write 0xEE without new start ignored.
REQ-038 rreq in IDLE -> rd_data=0xFF, rd_ack_tgl toggles, ptr unchanged.
